// File: rtl/key_sched.sv
`default_nettype none
// ============================================================================
//  Module   : key_sched
//  Purpose  : Iterative AES-128 key expansion. On an accepted key_load the
//             cipher key is emitted (addr 0), then one round key per cycle
//             up to addr NUM_ROUNDS, each tagged with its round address.
//  Option   : KEY_SCHED_STALL_EN adds a 'stall' input that freezes the
//             expansion and masks rkey_vld/done while asserted.
//  Revision : 1.0 - initial release
// ============================================================================
module key_sched #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst,       // asynchronous, active-low
  input  logic [127:0] key_in,
  input  logic         key_load,
  output logic         busy,
  output logic [127:0] rkey,
  output logic [3:0]   addr,
  output logic         rkey_vld,
  output logic         done
`ifdef KEY_SCHED_STALL_EN
  ,
  input  logic         stall
`endif
);

  localparam logic [3:0] c_last = 4'(NUM_ROUNDS);

  // Standard AES forward S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] c_sbox = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [10:0] idx;
    idx = 11'd2047 - {x, 3'b000};
    return c_sbox[idx -: 8];
  endfunction

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_EXPAND = 1'b1
  } state_t;

  state_t         r_state;
  logic [127:0]   r_rkey;
  logic [3:0]     r_addr;
  logic [7:0]     r_rcon;
  logic           r_vld;
  logic           r_busy;
  logic           r_done;

  logic           w_stall;
  logic [31:0]    w_rot;
  logic [31:0]    w_sub;
  logic [31:0]    w_t;
  logic [31:0]    w_n0, w_n1, w_n2, w_n3;
  logic [7:0]     w_rcon_next;

`ifdef KEY_SCHED_STALL_EN
  assign w_stall = stall;
`else
  assign w_stall = 1'b0;
`endif

  // RotWord of w3: byte-wise left rotate.
  assign w_rot = {r_rkey[23:0], r_rkey[31:24]};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sbox
      assign w_sub[gi*8 +: 8] = sbox(w_rot[gi*8 +: 8]);
    end
  endgenerate

  // Next round key, word chain w0' .. w3'.
  assign w_t  = w_sub ^ {r_rcon, 24'h000000};
  assign w_n0 = r_rkey[127:96] ^ w_t;
  assign w_n1 = r_rkey[95:64]  ^ w_n0;
  assign w_n2 = r_rkey[63:32]  ^ w_n1;
  assign w_n3 = r_rkey[31:0]   ^ w_n2;

  // xtime in GF(2^8) for the round constant.
  assign w_rcon_next = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);

  // Control FSM and round-key register; a stall freezes EXPAND in place.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_rkey  <= '0;
      r_addr  <= '0;
      r_rcon  <= 8'h01;
      r_vld   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (key_load) begin
            r_state <= ST_EXPAND;
            r_rkey  <= key_in;
            r_addr  <= 4'd0;
            r_rcon  <= 8'h01;
            r_vld   <= 1'b1;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end
        end
        ST_EXPAND: begin
          if (!w_stall) begin
            if (r_addr < c_last) begin
              r_rkey <= {w_n0, w_n1, w_n2, w_n3};
              r_addr <= r_addr + 4'd1;
              r_rcon <= w_rcon_next;
              r_done <= ((r_addr + 4'd1) == c_last);
            end else begin
              r_state <= ST_IDLE;
              r_rcon  <= 8'h01;
              r_vld   <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b0;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rkey     = r_rkey;
  assign addr     = r_addr;
  assign busy     = r_busy;
  assign rkey_vld = r_vld  & ~w_stall;
  assign done     = r_done & ~w_stall;

endmodule
`default_nettype wire

// File: tb/tb_key_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_key_sched
//  Purpose  : Directed self-checking bench for key_sched using the FIPS-197
//             AES-128 key expansion vectors.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_key_sched;

  logic         clk;
  logic         clk_en;
  logic         rst_n;
  logic [127:0] key_in;
  logic         key_load;
  logic         busy;
  logic [127:0] rkey;
  logic [3:0]   addr;
  logic         rkey_vld;
  logic         done;
`ifdef KEY_SCHED_STALL_EN
  logic         stall;
`endif

  int n_checks;
  int n_fail;

  logic [127:0] fips [0:10];
  localparam logic [127:0] c_zero_r1 = 128'h62636363626363636263636362636363;

  key_sched #(.NUM_ROUNDS(10)) dut (
    .clk      (clk),
    .rst      (rst_n),
    .key_in   (key_in),
    .key_load (key_load),
    .busy     (busy),
    .rkey     (rkey),
    .addr     (addr),
    .rkey_vld (rkey_vld),
    .done     (done)
`ifdef KEY_SCHED_STALL_EN
    ,
    .stall    (stall)
`endif
  );

  // Gateable clock, period 10; toggles stay on the 5-unit grid.
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Checks a full FIPS sequence; caller has key_load=1 with the FIPS key.
  // glitch_at: addr at which a foreign key_load is pulsed (-1 = none).
  // stall_at : addr at which a 3-cycle stall is applied (-1 = none).
  task automatic run_fips(input string tag, input int glitch_at, input int stall_at);
    step();
    key_load = 1'b0;
    for (int i = 0; i <= 10; i++) begin
      if (i > 0) step();
      if (i == glitch_at + 1) key_load = 1'b0;
      check({tag, "_rkey"}, rkey, fips[i]);
      check({tag, "_addr"}, 128'(addr), 128'(i));
      check({tag, "_vld"},  128'(rkey_vld), 128'd1);
      check({tag, "_done"}, 128'(done), 128'(i == 10));
      check({tag, "_busy"}, 128'(busy), 128'd1);
      if (i == glitch_at) begin
        key_load = 1'b1;
        key_in   = 128'hdeadbeef_00112233_44556677_8899aabb;
      end
`ifdef KEY_SCHED_STALL_EN
      if (i == stall_at) begin
        stall = 1'b1;
        #1;
        check({tag, "_stall_vld0"}, 128'(rkey_vld), 128'd0);
        for (int s = 0; s < 3; s++) begin
          step();
          check({tag, "_stall_addr"}, 128'(addr), 128'(i));
          check({tag, "_stall_vld"},  128'(rkey_vld), 128'd0);
          check({tag, "_stall_rkey"}, rkey, fips[i]);
        end
        stall = 1'b0;
        #1;
        check({tag, "_resume_vld"},  128'(rkey_vld), 128'd1);
        check({tag, "_resume_addr"}, 128'(addr), 128'(i));
      end
`endif
    end
    step();
    key_load = 1'b0;
    check({tag, "_end_vld"},  128'(rkey_vld), 128'd0);
    check({tag, "_end_busy"}, 128'(busy), 128'd0);
    check({tag, "_end_done"}, 128'(done), 128'd0);
    check({tag, "_end_addr"}, 128'(addr), 128'd10);
    check({tag, "_end_rkey"}, rkey, fips[10]);
  endtask

  initial begin
    fips[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    fips[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    n_checks = 0;
    n_fail   = 0;
    clk      = 1'b0;
    clk_en   = 1'b1;
    rst_n    = 1'b0;
    key_in   = '0;
    key_load = 1'b0;
`ifdef KEY_SCHED_STALL_EN
    stall    = 1'b0;
`endif

    // Reset state
    #12;
    check("rst_rkey", rkey, 128'd0);
    check("rst_addr", 128'(addr), 128'd0);
    check("rst_vld",  128'(rkey_vld), 128'd0);
    check("rst_done", 128'(done), 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    step();
    rst_n = 1'b1;
    step();
    check("idle_busy", 128'(busy), 128'd0);

    // Basic FIPS-197 sequence
    key_in   = fips[0];
    key_load = 1'b1;
    run_fips("fips", -1, -1);

    // Foreign key_load mid-sequence is ignored
    step();
    key_in   = fips[0];
    key_load = 1'b1;
    run_fips("glitch4", 4, -1);

    // key_load during the done cycle is ignored
    step();
    key_in   = fips[0];
    key_load = 1'b1;
    run_fips("glitch10", 10, -1);
    step();
    check("glitch10_noload", 128'(rkey_vld), 128'd0);

    // Asynchronous reset mid-sequence with the clock stopped
    key_in   = fips[0];
    key_load = 1'b1;
    step();
    key_load = 1'b0;
    for (int i = 1; i <= 6; i++) step();
    check("pre_rst_addr", 128'(addr), 128'd6);
    clk_en = 1'b0;
    #3;
    rst_n = 1'b0;
    #2;
    check("arst_rkey", rkey, 128'd0);
    check("arst_addr", 128'(addr), 128'd0);
    check("arst_vld",  128'(rkey_vld), 128'd0);
    check("arst_done", 128'(done), 128'd0);
    check("arst_busy", 128'(busy), 128'd0);
    #3;
    rst_n = 1'b1;
    #3;
    clk_en = 1'b1;
    step();
    check("post_rst_idle", 128'(busy), 128'd0);
    key_in   = fips[0];
    key_load = 1'b1;
    run_fips("restart", -1, -1);

    // key_load held high with a zero key: back-to-back sequences
    step();
    key_in   = '0;
    key_load = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      step();
      check("hold_vld", 128'(rkey_vld), 128'((c % 12) != 0));
      if ((c % 12) != 0)
        check("hold_addr", 128'(addr), 128'((c - 1) % 12));
      if (c == 2 || c == 14)
        check("hold_r1", rkey, c_zero_r1);
    end
    key_load = 1'b0;
    begin
      int budget;
      budget = 0;
      while (busy && budget < 20) begin
        step();
        budget++;
      end
      check("hold_drain", 128'(busy), 128'd0);
    end

`ifdef KEY_SCHED_STALL_EN
    // Stall for 3 cycles at addr 5
    step();
    key_in   = fips[0];
    key_load = 1'b1;
    run_fips("stall5", -1, 5);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
